// File: rtl/muldiv_iter_if.sv
// Handshake and register bus of the iterative multiply/divide unit.
// Signal names match the original flat port list of muldiv_iter.
interface muldiv_iter_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             we_hi;
   logic             we_lo;
   logic [WIDTH-1:0] wd;
   logic             busy;
   logic             done;
   logic             dbz;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, we_hi, we_lo, wd,
      input  busy, done, dbz, hi, lo
   );

   modport slave (
      input  start, op, a, b, we_hi, we_lo, wd,
      output busy, done, dbz, hi, lo
   );
endinterface

// File: rtl/muldiv_iter.sv
// Radix-2 iterative multiply/divide unit with HI/LO registers and MTHI/MTLO.
// Define MULDIV_SIGNED_EN to make op[0] select signed MULT/DIV.
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          rst,
   muldiv_iter_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             is_div;
   logic             dz;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] sh;
   logic [WIDTH-1:0] opnd;

   logic             busy_q;
   logic             done_q;
   logic             dbz_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH:0]   mul_part;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   rem_diff;
   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] sh_nxt;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;

`ifdef MULDIV_SIGNED_EN
   logic             sgn_a;
   logic             sgn_b;
   logic             neg_q;
   logic             neg_r;
   logic [2*WIDTH-1:0] prod_neg;

   assign sgn_a    = bus.op[0] & bus.a[WIDTH-1];
   assign sgn_b    = bus.op[0] & bus.b[WIDTH-1];
   assign mag_a    = sgn_a ? -bus.a : bus.a;
   assign mag_b    = sgn_b ? -bus.b : bus.b;
   assign prod_neg = -{acc, sh};
`else
   logic             unused_op0;

   assign unused_op0 = bus.op[0];
   assign mag_a      = bus.a;
   assign mag_b      = bus.b;
`endif

   // acc/sh form {product} while multiplying and {remainder, quotient} while dividing.
   always_comb begin
      mul_part  = sh[0] ? ({1'b0, acc} + {1'b0, opnd}) : {1'b0, acc};
      rem_shift = {acc, sh[WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, opnd};
      if (is_div) begin
         if (!rem_diff[WIDTH]) begin
            acc_nxt = rem_diff[WIDTH-1:0];
            sh_nxt  = {sh[WIDTH-2:0], 1'b1};
         end else begin
            acc_nxt = rem_shift[WIDTH-1:0];
            sh_nxt  = {sh[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_nxt = mul_part[WIDTH:1];
         sh_nxt  = {mul_part[0], sh[WIDTH-1:1]};
      end
   end

   always_comb begin
      res_hi = acc;
      res_lo = sh;
`ifdef MULDIV_SIGNED_EN
      if (is_div) begin
         if (neg_q) res_lo = -sh;
         if (neg_r) res_hi = -acc;
      end else if (neg_q) begin
         res_hi = prod_neg[2*WIDTH-1:WIDTH];
         res_lo = prod_neg[WIDTH-1:0];
      end
`endif
      // Divide-by-zero keeps the raw dividend in sh, so no sign fixup applies.
      if (dz) begin
         res_hi = sh;
         res_lo = '1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         is_div <= 1'b0;
         dz     <= 1'b0;
         acc    <= '0;
         sh     <= '0;
         opnd   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
`ifdef MULDIV_SIGNED_EN
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.we_hi) hi_q <= bus.wd;
               if (bus.we_lo) lo_q <= bus.wd;
               if (bus.start) begin
                  busy_q <= 1'b1;
                  dbz_q  <= 1'b0;
                  is_div <= bus.op[1];
                  cnt    <= CW'(WIDTH);
                  acc    <= '0;
                  opnd   <= mag_b;
`ifdef MULDIV_SIGNED_EN
                  neg_q  <= sgn_a ^ sgn_b;
                  neg_r  <= sgn_a;
`endif
                  if (bus.op[1] && (bus.b == '0)) begin
                     dz    <= 1'b1;
                     sh    <= bus.a;
                     state <= FINISH;
                  end else begin
                     dz    <= 1'b0;
                     sh    <= mag_a;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               acc <= acc_nxt;
               sh  <= sh_nxt;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= FINISH;
            end
            FINISH: begin
               hi_q   <= res_hi;
               lo_q   <= res_lo;
               dbz_q  <= dz;
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.dbz  = dbz_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter (WIDTH=32): latency, results, dbz, MTHI/MTLO,
// ignored starts, back-to-back issue and asynchronous reset.
module tb_muldiv_iter;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   n;
   int   bc;

   muldiv_iter_if #(.WIDTH(32)) bus ();

   muldiv_iter #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int cycles, output int busy_cycles);
      cycles      = 0;
      busy_cycles = 0;
      while (bus.done !== 1'b1 && cycles < limit) begin
         if (bus.busy === 1'b1) busy_cycles++;
         step();
         cycles++;
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
      issue(op, a, b);
      wait_done(100, n, bc);
      chk({tag, "_lat"}, n, 33);
      chk({tag, "_hi"}, bus.hi, exp_hi);
      chk({tag, "_lo"}, bus.lo, exp_lo);
      step();
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.a     = '0;
      bus.b     = '0;
      bus.we_hi = 1'b0;
      bus.we_lo = 1'b0;
      bus.wd    = '0;
      step();
      step();
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_dbz", bus.dbz, 0);
      chk("rst_hi", bus.hi, 0);
      chk("rst_lo", bus.lo, 0);
      rst = 1'b0;
      step();

      // MTHI / MTLO while idle
      bus.we_hi = 1'b1;
      bus.wd    = 32'hAAAA_0000;
      step();
      bus.we_hi = 1'b0;
      chk("mthi_hi", bus.hi, 32'hAAAA_0000);
      chk("mthi_busy", bus.busy, 0);
      chk("mthi_done", bus.done, 0);
      bus.we_lo = 1'b1;
      bus.wd    = 32'h0000_5555;
      step();
      bus.we_lo = 1'b0;
      chk("mtlo_lo", bus.lo, 32'h0000_5555);
      chk("mtlo_hi_kept", bus.hi, 32'hAAAA_0000);
      chk("mtlo_done", bus.done, 0);

      // MULTU max*max: busy 33 cycles, single done pulse
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("multu_busy_acc", bus.busy, 1);
      chk("multu_hi_hold", bus.hi, 32'hAAAA_0000);
      wait_done(100, n, bc);
      chk("multu_lat", n, 33);
      chk("multu_busycnt", bc, 33);
      chk("multu_busy_done", bus.busy, 0);
      chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
      chk("multu_lo", bus.lo, 32'h0000_0001);
      step();
      chk("multu_done_pulse", bus.done, 0);

      run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
      chk("divu_dbz", bus.dbz, 0);

      // divide by zero short path
      issue(2'b10, 32'd5, 32'd0);
      chk("dz_done_early", bus.done, 0);
      chk("dz_busy", bus.busy, 1);
      step();
      chk("dz_done", bus.done, 1);
      chk("dz_hi", bus.hi, 32'd5);
      chk("dz_lo", bus.lo, 32'hFFFF_FFFF);
      chk("dz_dbz", bus.dbz, 1);
      step();
      chk("dz_sticky", bus.dbz, 1);
      issue(2'b00, 32'd3, 32'd5);
      chk("dz_clear", bus.dbz, 0);
      wait_done(100, n, bc);
      chk("mul35_hi", bus.hi, 0);
      chk("mul35_lo", bus.lo, 32'd15);
      step();

      // starts and MTLO while busy are dropped
      issue(2'b00, 32'h1234_5678, 32'h0000_0100);
      for (int i = 0; i < 4; i++) step();
      bus.op    = 2'b10;
      bus.a     = 32'd7;
      bus.b     = 32'd7;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      bus.we_lo = 1'b1;
      bus.wd    = 32'h0000_1234;
      step();
      bus.we_lo = 1'b0;
      chk("run_lo_hold", bus.lo, 32'd15);
      chk("run_busy", bus.busy, 1);
      for (int i = 0; i < 9; i++) step();
      bus.op    = 2'b11;
      bus.a     = 32'd9;
      bus.b     = 32'd0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      wait_done(100, n, bc);
      chk("ign_lat", n, 13);
      chk("ign_hi", bus.hi, 32'h0000_0012);
      chk("ign_lo", bus.lo, 32'h3456_7800);
      chk("ign_dbz", bus.dbz, 0);

      // new start issued during the done cycle is accepted
      issue(2'b10, 32'hFFFF_FFFF, 32'h0000_0010);
      chk("b2b_busy", bus.busy, 1);
      wait_done(100, n, bc);
      chk("b2b_lat", n, 33);
      chk("b2b_hi", bus.hi, 32'h0000_000F);
      chk("b2b_lo", bus.lo, 32'h0FFF_FFFF);
      step();

      // MTHI in the same cycle as start: write lands, result overwrites later
      bus.we_hi = 1'b1;
      bus.wd    = 32'h0000_DEAD;
      issue(2'b00, 32'd2, 32'd3);
      bus.we_hi = 1'b0;
      chk("same_cyc_hi", bus.hi, 32'h0000_DEAD);
      wait_done(100, n, bc);
      chk("same_cyc_res_hi", bus.hi, 0);
      chk("same_cyc_res_lo", bus.lo, 32'd6);
      step();

`ifdef MULDIV_SIGNED_EN
      run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("mult_m3_4", 2'b01, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
      run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      chk("div_ovf_dbz", bus.dbz, 0);
      issue(2'b11, 32'hFFFF_FFFB, 32'd0);
      step();
      chk("sdz_done", bus.done, 1);
      chk("sdz_hi", bus.hi, 32'hFFFF_FFFB);
      chk("sdz_lo", bus.lo, 32'hFFFF_FFFF);
      step();
`else
      run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC);
      run_op("mult_m3_4", 2'b01, 32'hFFFF_FFFD, 32'd4, 32'h0000_0003, 32'hFFFF_FFF4);
      run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
`endif

      // asynchronous reset at cycle 10 of a DIVU
      issue(2'b10, 32'd1000, 32'd3);
      for (int i = 0; i < 9; i++) step();
      rst = 1'b1;
      #1;
      chk("arst_busy", bus.busy, 0);
      chk("arst_hi", bus.hi, 0);
      chk("arst_lo", bus.lo, 0);
      step();
      rst = 1'b0;
      wait_done(40, n, bc);
      chk("arst_no_done", n, 40);
      run_op("post_rst_mul", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Iterative multiply/divide unit with HI/LO result registers, parametrised in WIDTH.
- Replaces the single-cycle combinational multiplier in the datapath. Adds division, divide-by-zero detection, MTHI/MTLO writes and a start/busy/done handshake.
- The controller stalls on busy. MFHI/MFLO read hi/lo directly.

Parameters:
WIDTH, 32, operand and HI/LO register width (>=4)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  request an operation; sampled only when busy=0
op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a  in  WIDTH  multiplicand / dividend
b  in  WIDTH  multiplier / divisor
we_hi  in  1  MTHI: load hi from wd
we_lo  in  1  MTLO: load lo from wd
wd  in  WIDTH  write data for MTHI/MTLO
busy  out  1  operation in progress
done  out  1  one-cycle pulse; hi/lo hold the new result
dbz  out  1  last completed divide had b=0; sticky until the next accepted start
hi  out  WIDTH  HI register (product upper half / remainder)
lo  out  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - busy=0, done=0, dbz=0, hi=0, lo=0.
  - Internal accumulators are cleared.
  - Reset mid-operation abandons the operation; no done pulse.
- Operation state machine:
  - IDLE -> RUN: on an edge with start=1. a, b and op are latched; the iteration counter is loaded with WIDTH; busy=1 from that edge.
  - RUN: one radix-2 iteration per clock.
    - Multiply: shift-add. The 2*WIDTH product is formed in a {acc, mplr} shift register.
    - Divide: restoring shift-subtract, using a WIDTH+1-bit partial remainder.
    - The counter decrements each cycle; RUN -> FINISH when the counter reaches 1.
  - FINISH -> IDLE: hi/lo are written on this edge, done=1 for one cycle, busy=0.
- Latency:
  - done is high during the cycle after edge N+WIDTH+1, where N is the accepting edge. For WIDTH=32 that is 33 clocks after acceptance.
  - A new start is accepted during the done cycle, so back-to-back operations are supported.
- Divide by zero (op[1]=1, b=0):
  - IDLE -> FINISH directly; done appears 2 edges after acceptance.
  - Result: hi=a, lo={WIDTH{1}}, dbz=1.
- start while busy=1 is ignored: no queueing, operands not re-latched.
- MTHI/MTLO:
  - we_hi/we_lo write hi/lo at the next edge only when busy=0 and the state is not FINISH.
  - While busy, writes are dropped.
  - If start and we_hi/we_lo occur in the same cycle, the write still occurs and the operation starts; the result later overwrites hi/lo.
- hi/lo change only on FINISH, MTHI/MTLO or reset. They hold their value otherwise, including throughout RUN.
- dbz is cleared on every accepted start and set only at FINISH of a divide-by-zero.

Optional Feature:
MULDIV_SIGNED_EN
- Defined:
  - op[0]=1 selects signed (two's-complement) operation.
  - Operands are converted to magnitudes at accept. The result sign is fixed up in FINISH with no added latency.
  - Division truncates toward zero; the remainder takes the sign of the dividend.
  - Overflow case: DIV of most-negative by -1 gives lo=most-negative, hi=0, dbz=0.
- Undefined:
  - op[0] is ignored; MULT behaves as MULTU and DIV as DIVU.
  - No sign-fixup logic is synthesised.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 33 cycles, done once, hi=0xFFFFFFFE, lo=0x00000001.
- DIVU a=100, b=7 -> lo=14, hi=2, dbz=0. Then DIVU a=5, b=0 -> done 2 edges after accept, hi=5, lo=0xFFFFFFFF, dbz=1. Next start clears dbz.
- With MULDIV_SIGNED_EN:
  - DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - MULT a=-3, b=4 -> hi=0xFFFFFFFF, lo=0xFFFFFFF4.
  - DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Issue start with different operands at cycles 5 and 20 of a running MULTU -> both ignored. Issue we_lo=1, wd=0x1234 mid-run -> dropped. The first result is unchanged; a start during the done cycle is accepted.
- Assert rst at cycle 10 of a DIVU -> busy=0, hi=lo=0 immediately, no done pulse. A MULTU 3*5 after release gives hi=0, lo=15.
- MTHI wd=0xAAAA0000 and MTLO wd=0x5555 while idle -> hi/lo updated next edge, busy stays 0, done stays 0.
